// File: rtl/jk_bank_seq.sv
// rtl/jk_bank_seq.sv - command sequencer driving an internal bank of JK cells
// Optional feature macro: JK_SEQ_DOWN_EN (enables down-counting via cmd_dir)
module jk_bank_seq #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              cmd_dir,
   input  logic              abort,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qbar,
   output logic [WIDTH-1:0]  jk_j,
   output logic [WIDTH-1:0]  jk_k,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              wrap
);

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_COUNT  = 2'b10;
   localparam logic [1:0] OP_INVERT = 2'b11;

   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [STEP_W-1:0] STEP_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [STEP_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]    q_q, q_d;
   logic [WIDTH-1:0]    qbar_q, qbar_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                wrap_q, wrap_d;
   logic [WIDTH-1:0]    j_c, k_c;
   logic [WIDTH-1:0]    tog_up;
   logic [WIDTH-1:0]    tog_cnt;
   logic                wrap_hit;

   // Synchronous binary counter: bit i toggles when every lower bit is 1 (up).
   always_comb begin
      tog_up    = '0;
      tog_up[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tog_up[i] = tog_up[i-1] & q_q[i-1];
      end
   end

`ifdef JK_SEQ_DOWN_EN
   logic                dir_q, dir_d;
   logic [WIDTH-1:0]    tog_dn;

   // Down count: bit i toggles when every lower bit is 0.
   always_comb begin
      tog_dn    = '0;
      tog_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tog_dn[i] = tog_dn[i-1] & ~q_q[i-1];
      end
   end

   always_comb begin
      dir_d = dir_q;
      if (state_q == S_IDLE && cmd_valid) begin
         dir_d = cmd_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir_d;
      end
   end

   assign tog_cnt  = dir_q ? tog_dn : tog_up;
   assign wrap_hit = dir_q ? (q_q == '0) : (q_q == '1);
`else
   logic unused_dir;
   assign unused_dir = cmd_dir;
   assign tog_cnt    = tog_up;
   assign wrap_hit   = (q_q == '1);
`endif

   // J/K applied to the bank; an abort in RUN forces hold for that cycle.
   always_comb begin
      j_c = '0;
      k_c = '0;
      case (state_q)
         S_EXEC: begin
            case (op_q)
               OP_CLEAR: begin
                  j_c = '0;
                  k_c = '1;
               end
               OP_LOAD: begin
                  j_c = data_q;
                  k_c = ~data_q;
               end
               OP_INVERT: begin
                  j_c = '1;
                  k_c = '1;
               end
               default: begin
                  j_c = '0;
                  k_c = '0;
               end
            endcase
         end
         S_RUN: begin
            if (!abort && steps_q != STEP_ZERO) begin
               j_c = tog_cnt;
               k_c = tog_cnt;
            end
         end
         default: begin
            j_c = '0;
            k_c = '0;
         end
      endcase
   end

   // JK cell bank
   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({j_c[i], k_c[i]})
            2'b00:   q_d[i] = q_q[i];
            2'b01:   q_d[i] = 1'b0;
            2'b10:   q_d[i] = 1'b1;
            default: q_d[i] = ~q_q[i];
         endcase
      end
      qbar_d = ~q_d;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      steps_d   = steps_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      wrap_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               steps_d = cmd_steps;
               cnt_d   = STEP_ZERO;
               state_d = (cmd_op == OP_COUNT) ? S_RUN : S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_RUN: begin
            if (abort) begin
               state_d   = S_IDLE;
               aborted_d = 1'b1;
            end else if (steps_q == STEP_ZERO) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d  = cnt_q + STEP_ONE;
               wrap_d = wrap_hit;
               if (cnt_q == steps_q - STEP_ONE) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_CLEAR;
         data_q    <= '0;
         steps_q   <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         qbar_q    <= '1;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         data_q    <= data_d;
         steps_q   <= steps_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         qbar_q    <= qbar_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         wrap_q    <= wrap_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = ~cmd_ready;
   assign q         = q_q;
   assign qbar      = qbar_q;
   assign jk_j      = j_c;
   assign jk_k      = k_c;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_jk_bank_seq.sv
// tb/tb_jk_bank_seq.sv - scoreboard bench for jk_bank_seq (WIDTH=4)
module tb_jk_bank_seq;

   localparam int WIDTH  = 4;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [WIDTH-1:0]  cmd_data = '0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic              cmd_dir = 1'b0;
   logic              abort = 1'b0;
   logic [WIDTH-1:0]  q, qbar, jk_j, jk_k;
   logic              busy, done, aborted, wrap;

   jk_bank_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
      .abort(abort), .q(q), .qbar(qbar), .jk_j(jk_j), .jk_k(jk_k), .busy(busy),
      .done(done), .aborted(aborted), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         ab;
      logic [3:0] qv;
      int         wraps;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   wrap_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every done/aborted pulse pops one expected completion.
   always @(negedge clk) begin
      if (rst) begin
         wrap_cnt = 0;
      end else begin
         if (wrap) wrap_cnt++;
         if (done || aborted) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {30'd0, done, aborted}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("kind_aborted", {31'd0, aborted}, {31'd0, e.ab});
               chk("kind_done", {31'd0, done}, {31'd0, !e.ab});
               chk("q_at_end", {28'd0, q}, {28'd0, e.qv});
               chk("qbar_at_end", {28'd0, qbar}, {28'd0, ~e.qv});
               chk("wrap_count", wrap_cnt, e.wraps);
            end
            wrap_cnt = 0;
         end
      end
   end

   // Called at a negedge; returns just after the accepting edge E0.
   task automatic issue(input logic [1:0] op, input logic [3:0] data,
                        input logic [7:0] steps, input logic dir,
                        input bit ab, input logic [3:0] qv, input int wraps);
      exp_t e;
      e.ab = ab; e.qv = qv; e.wraps = wraps;
      exp_q.push_back(e);
      chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
      cmd_op = op; cmd_data = data; cmd_steps = steps; cmd_dir = dir;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 2'b00; cmd_data = 4'hf; cmd_steps = 8'hff; cmd_dir = 1'b1;
   endtask

   task automatic wait_idle(output int busy_cycles);
      bit ok = 0;
      busy_cycles = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
         if (busy) busy_cycles++;
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   int bc;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_q", {28'd0, q}, 32'h0);
      chk("rst_qbar", {28'd0, qbar}, 32'hf);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_pulses", {29'd0, done, aborted, wrap}, 32'd0);
      chk("rst_jk", {24'd0, jk_j, jk_k}, 32'd0);

      issue(2'b01, 4'b1010, 8'd0, 1'b0, 0, 4'b1010, 0);
      wait_idle(bc);
      chk("load_busy_cycles", bc, 1);
      issue(2'b11, 4'b0000, 8'd0, 1'b0, 0, 4'b0101, 0);
      wait_idle(bc);
      issue(2'b01, 4'b1111, 8'd0, 1'b0, 0, 4'b1111, 0);
      wait_idle(bc);
      issue(2'b00, 4'b1111, 8'd0, 1'b0, 0, 4'b0000, 0);
      wait_idle(bc);

      issue(2'b10, 4'b0000, 8'd20, 1'b0, 0, 4'b0100, 1);
      wait_idle(bc);
      chk("count20_busy_cycles", bc, 20);

      issue(2'b10, 4'b0000, 8'd0, 1'b0, 0, 4'b0100, 0);
      wait_idle(bc);
      chk("count0_busy_cycles", bc, 1);

      issue(2'b00, 4'b0000, 8'd0, 1'b0, 0, 4'b0000, 0);
      wait_idle(bc);
      issue(2'b10, 4'b0000, 8'd10, 1'b0, 1, 4'b0010, 0);
      repeat (2) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_idle(bc);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);

      // Reset at E5 of a 10-step count: no completion is pushed.
      cmd_op = 2'b10; cmd_steps = 8'd10; cmd_dir = 1'b0;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_q", {28'd0, q}, 32'h0);
      chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
      repeat (12) @(negedge clk);
      chk("midrst_idle_after", {31'd0, cmd_ready}, 32'd1);

`ifdef JK_SEQ_DOWN_EN
      issue(2'b10, 4'b0000, 8'd3, 1'b1, 0, 4'b1101, 1);
`else
      issue(2'b10, 4'b0000, 8'd3, 1'b1, 0, 4'b0011, 0);
`endif
      wait_idle(bc);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
